alu_arbiter: RTL and testbench

//   Shares one 8-bit ALU instance among NUM_REQ requesters.
//   - Round-robin grant; one operation in flight at a time.
//   - Per-requester valid/ready request channel.
//   - Single response channel tagged with the requester index.
//   - Registers operands before the ALU and results after it, so the ALU is

---
 rtl/alu_arbiter_pkg.sv | 54 +++++
 rtl/alu_arbiter_rr_arbiter.sv | 29 ++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and the ALU datapath.
package alu_arbiter_pkg;

  localparam int ALU_DW = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ALU_DW-1:0] out;
    logic              carry;
  } alu_res_t;

  // Carry is meaningful only for add; all other ops report carry = 0.
  function automatic alu_res_t alu_eval(input logic [ALU_DW-1:0] a,
                                        input logic [ALU_DW-1:0] b,
                                        input alu_op_e op);
    alu_res_t        r;
    logic [ALU_DW:0] sum;
    sum     = {1'b0, a} + {1'b0, b};
    r.out   = '0;
    r.carry = 1'b0;
    case (op)
      ALU_ADD: begin
        r.out   = sum[ALU_DW-1:0];
        r.carry = sum[ALU_DW];
      end
      ALU_SUB: r.out = a - b;
      ALU_AND: r.out = a & b;
      ALU_OR:  r.out = a | b;
      ALU_XOR: r.out = a ^ b;
      ALU_NOT: r.out = ~a;
      ALU_SHL: r.out = a << 1;
      ALU_SHR: r.out = a >> 1;
      default: r.out = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int unsigned pos;

  // Scan from lowest to highest priority so the last hit (closest after ptr) wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    for (int unsigned k = N; k >= 1; k--) begin
      pos = (32'(ptr_i) + k) % 32'(N);
      if (req_i[IW'(pos)]) begin
        gnt_o          = '0;
        gnt_o[IW'(pos)] = 1'b1;
        idx_o          = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered 8-bit ALU among NUM_REQ requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [ALU_DW*NUM_REQ-1:0] req_a,
  input  logic [ALU_DW*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [ALU_DW-1:0]         rsp_out,
  output logic                      rsp_zero,
  output logic                      rsp_carry,
  output logic                      busy
);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q, id_q, rsp_id_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [ALU_DW-1:0] a_q, b_q, rsp_out_q;
  alu_op_e           op_q;
  logic              rsp_zero_q, rsp_carry_q;
  logic              grant_fire;
  alu_res_t          alu_res;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign alu_res = alu_eval(a_q, b_q, op_q);

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    grant_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|req_valid) && !rst) begin
          req_ready  = gnt;
          grant_fire = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ALU_ADD;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        a_q   <= req_a[gnt_idx*ALU_DW +: ALU_DW];
        b_q   <= req_b[gnt_idx*ALU_DW +: ALU_DW];
        op_q  <= alu_op_e'(req_op[gnt_idx*3 +: 3]);
        id_q  <= gnt_idx;
        ptr_q <= gnt_idx;
      end
      if (state_q == S_EXEC) begin
        rsp_out_q   <= alu_res.out;
        rsp_zero_q  <= (alu_res.out == '0);
        rsp_carry_q <= alu_res.carry;
        rsp_id_q    <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic reference of the ALU and round-robin rules.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_out;
  logic        rsp_zero, rsp_carry, busy;

  logic [7:0] ra[4];
  logic [7:0] rb[4];
  logic [2:0] ro[4];

  assign req_a  = {ra[3], ra[2], ra[1], ra[0]};
  assign req_b  = {rb[3], rb[2], rb[1], rb[0]};
  assign req_op = {ro[3], ro[2], ro[1], ro[0]};

  int checks = 0;
  int errors = 0;
  int m_ptr  = 3;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  // Reference model
  function automatic int ref_out(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * 2) % 256;
      default: return a / 2;
    endcase
  endfunction

  function automatic int ref_carry(input int a, input int b, input int op);
    return (op == 0 && (a + b) > 255) ? 1 : 0;
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (p + i) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int op);
    ra[i] = 8'(a);
    rb[i] = 8'(b);
    ro[i] = 3'(op);
  endtask

  task automatic rand_req(input int i);
    set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)));
  endtask

  // Returns granted index (-1 timeout, -2 not one-hot); ends just after the grant edge.
  task automatic find_grant(output int g);
    g = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        if ($countones(req_ready) != 1) g = -2;
        else for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        step();
        return;
      end
      step();
    end
  endtask

  // Counts falling edges until rsp_valid; -1 on timeout. Ends at that falling edge.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin
        ok = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int g;
    bit ok;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) rand_req(i);
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0000", req_ready);
    end
    step();
    rst = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b busy=%b exp 0000/0/0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_out !== 8'h00 || rsp_id !== 2'd0 || rsp_zero !== 1'b0 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got out=%h id=%0d z=%b c=%b exp 00/0/0/0",
               rsp_out, rsp_id, rsp_zero, rsp_carry);
    end
    step();
    m_ptr = 3;
    req_valid = 4'b0100;
    find_grant(g);
    checks++;
    if (g !== model_grant(4'b0100, m_ptr)) begin
      errors++; $display("FAIL first_grant got %0d exp %0d", g, model_grant(4'b0100, m_ptr));
    end
    m_ptr = 2;
    req_valid = 4'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL first_drain got busy exp idle"); end
  endtask

  task automatic test_add();
    int g, lat;
    bit ok;
    set_req(0, 'hF0, 'h20, 0);
    req_valid = 4'b0001;
    find_grant(g);
    checks++;
    if (g !== 0) begin errors++; $display("FAIL add_grant got %0d exp 0", g); end
    m_ptr = 0;
    req_valid = 4'b0;
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++;
    if (rsp_out !== 8'h10 || rsp_carry !== 1'b1 || rsp_zero !== 1'b0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL add_result got out=%h c=%b z=%b id=%0d exp 10/1/0/0",
               rsp_out, rsp_carry, rsp_zero, rsp_id);
    end
    step();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_drain got busy exp idle"); end
  endtask

  task automatic test_round_robin();
    int g, exp_g, lat, t, prev_t, eo, ec;
    bit ok;
    prev_t = 0;
    for (int i = 0; i < 4; i++) rand_req(i);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_g = model_grant(4'hF, m_ptr);
      find_grant(g);
      t = cyc_cnt;
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", n, g, exp_g); end
      if (n > 0) begin
        checks++;
        if (t - prev_t !== 3) begin
          errors++; $display("FAIL rr_spacing%0d got %0d exp 3", n, t - prev_t);
        end
      end
      prev_t = t;
      eo = ref_out(ra[exp_g], rb[exp_g], ro[exp_g]);
      ec = ref_carry(ra[exp_g], rb[exp_g], ro[exp_g]);
      m_ptr = exp_g;
      rand_req(exp_g);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_out !== 8'(eo) || rsp_carry !== 1'(ec) || rsp_id !== 2'(exp_g)) begin
        errors++;
        $display("FAIL rr_rsp%0d got lat=%0d out=%h c=%b id=%0d exp 2/%h/%0d/%0d",
                 n, lat, rsp_out, rsp_carry, rsp_id, eo, ec, exp_g);
      end
      step();
    end
    req_valid = 4'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain got busy exp idle"); end
  endtask

  task automatic test_backpressure();
    int g, lat, eo, ec;
    rand_req(1);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    find_grant(g);
    checks++;
    if (g !== 1) begin errors++; $display("FAIL bp_grant got %0d exp 1", g); end
    m_ptr = 1;
    eo = ref_out(ra[1], rb[1], ro[1]);
    ec = ref_carry(ra[1], rb[1], ro[1]);
    req_valid = 4'b1101;
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", lat); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== 8'(eo) || rsp_id !== 2'd1 ||
          rsp_zero !== 1'(eo == 0) || rsp_carry !== 1'(ec)) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b out=%h id=%0d z=%b c=%b exp 1/%h/1/%0d/%0d",
                 k, rsp_valid, rsp_out, rsp_id, rsp_zero, rsp_carry, eo, eo == 0, ec);
      end
      checks++;
      if (busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++; $display("FAIL bp_stall%0d got busy=%b ready=%b exp 1/0000", k, busy, req_ready);
      end
      step();
      @(negedge clk);
    end
    step();
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b busy=%b exp 0/0", rsp_valid, busy);
    end
    step();
  endtask

  task automatic test_flags();
    int g, lat, r;
    logic [2:0] f_op[5] = '{3'd1, 3'd7, 3'd5, 3'd0, 3'd6};
    logic [7:0] f_a[5]  = '{8'h05, 8'h01, 8'h00, 8'hFF, 8'h80};
    logic [7:0] f_b[5]  = '{8'h05, 8'h3C, 8'hA5, 8'h01, 8'h11};
    logic [7:0] f_o[5]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic       f_z[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       f_c[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      r = int'($urandom_range(0, 3));
      set_req(r, int'(f_a[n]), int'(f_b[n]), int'(f_op[n]));
      req_valid = 4'(1 << r);
      find_grant(g);
      checks++;
      if (g !== r) begin errors++; $display("FAIL flag_grant%0d got %0d exp %0d", n, g, r); end
      m_ptr = r;
      req_valid = 4'b0;
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_out !== f_o[n] || rsp_zero !== f_z[n] || rsp_carry !== f_c[n]) begin
        errors++;
        $display("FAIL flag_case%0d got lat=%0d out=%h z=%b c=%b exp 2/%h/%b/%b",
                 n, lat, rsp_out, rsp_zero, rsp_carry, f_o[n], f_z[n], f_c[n]);
      end
      step();
    end
  endtask

  task automatic test_reset_exec();
    int g, lat;
    bit ok;
    rand_req(1);
    req_valid = 4'b0010;
    find_grant(g);
    checks++;
    if (g !== 1) begin errors++; $display("FAIL rexec_grant got %0d exp 1", g); end
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL rexec_ready got %b exp 0000", req_ready);
    end
    step();
    rst = 1'b0;
    req_valid = 4'b0;
    m_ptr = 3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rexec_quiet%0d got v=%b busy=%b exp 0/0", k, rsp_valid, busy);
      end
      step();
    end
    for (int i = 0; i < 4; i++) rand_req(i);
    req_valid = 4'hF;
    find_grant(g);
    checks++;
    if (g !== model_grant(4'hF, m_ptr)) begin
      errors++; $display("FAIL rexec_regrant got %0d exp %0d", g, model_grant(4'hF, m_ptr));
    end
    m_ptr = 0;
    req_valid = 4'b0;
    wait_rsp(lat);
    checks++;
    if (lat !== 2 || rsp_id !== 2'd0 || rsp_out !== 8'(ref_out(ra[0], rb[0], ro[0]))) begin
      errors++;
      $display("FAIL rexec_rsp got lat=%0d id=%0d out=%h exp 2/0/%h",
               lat, rsp_id, rsp_out, ref_out(ra[0], rb[0], ro[0]));
    end
    step();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rexec_drain got busy exp idle"); end
  endtask

  task automatic test_random();
    int g, exp_g, lat, eo, ec, d;
    logic [3:0] m;
    for (int n = 0; n < 40; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) rand_req(i);
      req_valid = m;
      rsp_ready = 1'b1;
      exp_g = model_grant(m, m_ptr);
      find_grant(g);
      checks++;
      if (g !== exp_g) begin
        errors++; $display("FAIL rnd_grant%0d got %0d exp %0d mask %b", n, g, exp_g, m);
      end
      eo = ref_out(ra[exp_g], rb[exp_g], ro[exp_g]);
      ec = ref_carry(ra[exp_g], rb[exp_g], ro[exp_g]);
      m_ptr = exp_g;
      req_valid = 4'b0;
      d = int'($urandom_range(0, 3));
      rsp_ready = (d == 0);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_out !== 8'(eo) || rsp_zero !== 1'(eo == 0) ||
          rsp_carry !== 1'(ec) || rsp_id !== 2'(exp_g)) begin
        errors++;
        $display("FAIL rnd_rsp%0d got lat=%0d out=%h z=%b c=%b id=%0d exp 2/%h/%0d/%0d/%0d",
                 n, lat, rsp_out, rsp_zero, rsp_carry, rsp_id, eo, eo == 0, ec, exp_g);
      end
      for (int k = 0; k < d; k++) begin
        step();
        if (k == d - 1) rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_out !== 8'(eo)) begin
          errors++;
          $display("FAIL rnd_hold%0d got v=%b out=%h exp 1/%h", n, rsp_valid, rsp_out, eo);
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 0, 0, 0);
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_reset_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
